// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter: FSM states, completion status codes
// and header field layout.
package router_pkg;

   localparam int unsigned LEN_W       = 6;
   localparam int unsigned ADDR_W      = 2;
   localparam int unsigned HDR_LEN_LSB = 2;

   localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'd3;

   localparam logic [1:0] ST_OK     = 2'b00;
   localparam logic [1:0] ST_PERR   = 2'b01;
   localparam logic [1:0] ST_BADCMD = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StCollect,
      StHeader,
      StPayload,
      StParity,
      StWaitDone
   } tx_state_e;

   // Header byte is {len[7:2], addr[1:0]}
   function automatic logic [7:0] make_header(input logic [LEN_W-1:0]  len,
                                              input logic [ADDR_W-1:0] addr);
      logic [7:0] hdr;
      hdr = '0;
      hdr[HDR_LEN_LSB +: LEN_W] = len;
      hdr[ADDR_W-1:0]           = addr;
      return hdr;
   endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Command, payload and router-side signals of the packet transmitter.
// master is the transmitter side, slave is the traffic generator / router side.
interface router_pkt_tx_if;
   import router_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [LEN_W-1:0]  req_len;
   logic              req_corrupt;
   logic              pl_valid;
   logic              pl_ready;
   logic [7:0]        pl_data;
   logic [7:0]        data_out;
   logic              pkt_valid;
   logic              busy;
   logic              err;
   logic              done;
   logic [1:0]        done_status;

   modport master (
      input  req_valid, req_addr, req_len, req_corrupt, pl_valid, pl_data, busy, err,
      output req_ready, pl_ready, data_out, pkt_valid, done, done_status
   );

   modport slave (
      output req_valid, req_addr, req_len, req_corrupt, pl_valid, pl_data, busy, err,
      input  req_ready, pl_ready, data_out, pkt_valid, done, done_status
   );

endinterface

// File: rtl/tx_pkt_buf.sv
// Synchronous single-clock FIFO with read-ahead output (rd_data shows the head entry).
module tx_pkt_buf #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   // Extra MSB distinguishes full from empty; the low bits wrap naturally
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_push;
   logic             w_pop;

   assign w_push = wr_en && !full;
   assign w_pop  = rd_en && !empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
   end

   assign rd_data = r_mem[r_rd_ptr[AW-1:0]];
   assign empty   = (r_wr_ptr == r_rd_ptr);
   assign full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: buffers a whole payload, then sends header, payload and parity
// paced by the router's busy signal, and reports the router's parity verdict.
module router_pkt_tx
   import router_pkg::*;
#(
   parameter int unsigned MAX_LEN   = 63,
   parameter int unsigned BUF_DEPTH = 64
) (
   input  logic            clk,
   input  logic            rst,
   router_pkt_tx_if.master bus
);

   tx_state_e         r_state, w_state;
   logic [ADDR_W-1:0] r_addr, w_addr;
   logic [LEN_W-1:0]  r_len, w_len;
   logic              r_corrupt, w_corrupt;
   logic [LEN_W-1:0]  r_cnt, w_cnt;
   logic [7:0]        r_parity, w_parity;
   logic [7:0]        r_data_out, w_data_out;
   logic              r_pkt_valid, w_pkt_valid;
   logic              r_seen_busy, w_seen_busy;
   logic              r_done, w_done;
   logic [1:0]        r_done_status, w_done_status;

   logic              w_wr_en, w_rd_en, w_empty, w_full;
   logic [7:0]        w_rd_data;
   logic              w_cmd_bad, w_pl_ready;

   tx_pkt_buf #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (8)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (w_wr_en),
      .wr_data (bus.pl_data),
      .rd_en   (w_rd_en),
      .rd_data (w_rd_data),
      .empty   (w_empty),
      .full    (w_full)
   );

   assign w_cmd_bad = (bus.req_len == '0) || (bus.req_addr == ADDR_ILLEGAL) ||
                      (32'(bus.req_len) > MAX_LEN);
   assign w_pl_ready = (r_state == StCollect) && (r_cnt < r_len) && !w_full && !rst;

   assign bus.req_ready   = (r_state == StIdle) && !rst;
   assign bus.pl_ready    = w_pl_ready;
   assign bus.data_out    = r_data_out;
   assign bus.pkt_valid   = r_pkt_valid;
   assign bus.done        = r_done;
   assign bus.done_status = r_done_status;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= StIdle;
         r_addr        <= '0;
         r_len         <= '0;
         r_corrupt     <= 1'b0;
         r_cnt         <= '0;
         r_parity      <= '0;
         r_data_out    <= '0;
         r_pkt_valid   <= 1'b0;
         r_seen_busy   <= 1'b0;
         r_done        <= 1'b0;
         r_done_status <= '0;
      end else begin
         r_state       <= w_state;
         r_addr        <= w_addr;
         r_len         <= w_len;
         r_corrupt     <= w_corrupt;
         r_cnt         <= w_cnt;
         r_parity      <= w_parity;
         r_data_out    <= w_data_out;
         r_pkt_valid   <= w_pkt_valid;
         r_seen_busy   <= w_seen_busy;
         r_done        <= w_done;
         r_done_status <= w_done_status;
      end
   end

   always_comb begin
      w_state       = r_state;
      w_addr        = r_addr;
      w_len         = r_len;
      w_corrupt     = r_corrupt;
      w_cnt         = r_cnt;
      w_parity      = r_parity;
      w_data_out    = r_data_out;
      w_pkt_valid   = r_pkt_valid;
      w_seen_busy   = r_seen_busy;
      w_done        = 1'b0;
      w_done_status = r_done_status;
      w_wr_en       = 1'b0;
      w_rd_en       = 1'b0;

      unique case (r_state)
         StIdle: begin
            if (bus.req_valid) begin
               if (w_cmd_bad) begin
                  w_done        = 1'b1;
                  w_done_status = ST_BADCMD;
               end else begin
                  w_addr    = bus.req_addr;
                  w_len     = bus.req_len;
                  w_corrupt = bus.req_corrupt;
                  w_cnt     = '0;
                  w_state   = StCollect;
               end
            end
         end
         StCollect: begin
            if (bus.pl_valid && w_pl_ready) begin
               w_wr_en = 1'b1;
               w_cnt   = r_cnt + 6'd1;
               if ((r_cnt + 6'd1) == r_len) begin
                  w_data_out  = make_header(r_len, r_addr);
                  w_parity    = make_header(r_len, r_addr);
                  w_pkt_valid = 1'b1;
                  w_state     = StHeader;
               end
            end
         end
         StHeader: begin
            if (!bus.busy && !w_empty) begin
               w_data_out  = w_rd_data;
               w_pkt_valid = 1'b1;
               w_rd_en     = 1'b1;
               w_cnt       = '0;
               w_state     = StPayload;
            end
         end
         StPayload: begin
            if (!bus.busy) begin
               w_parity = r_parity ^ r_data_out;
               w_cnt    = r_cnt + 6'd1;
               if (r_cnt == (r_len - 6'd1)) begin
                  w_data_out  = r_parity ^ r_data_out ^ {8{r_corrupt}};
                  w_pkt_valid = 1'b0;
                  w_state     = StParity;
               end else begin
                  w_data_out = w_rd_data;
                  w_rd_en    = 1'b1;
               end
            end
         end
         StParity: begin
            if (!bus.busy) begin
               w_data_out  = '0;
               w_seen_busy = 1'b0;
               w_state     = StWaitDone;
            end
         end
         StWaitDone: begin
            // Router must go busy (checking parity) and then release before we report
            if (bus.busy) begin
               w_seen_busy = 1'b1;
            end else if (r_seen_busy) begin
               w_done        = 1'b1;
               w_done_status = bus.err ? ST_PERR : ST_OK;
               w_state       = StIdle;
            end
         end
         default: w_state = StIdle;
      endcase
   end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Randomised and directed bench for router_pkt_tx against a packet-level reference model.
module tb_router_pkt_tx;

   logic clk = 1'b0;
   logic rst = 1'b1;

   router_pkt_tx_if bus ();

   router_pkt_tx #(
      .MAX_LEN   (63),
      .BUF_DEPTH (64)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef enum int {PIdle, PCollect, PActive, PWait} ph_e;

   int         n_cmp = 0;
   int         n_bad = 0;

   // Packet-level model state
   ph_e        m_ph = PIdle;
   int         m_idx = 0;
   int         m_len = 0;
   int         m_addr = 0;
   bit         m_cor = 0;
   bit         m_seen = 0;
   bit         m_done_exp = 0;
   int         m_status = 0;
   bit         m_nd;
   logic [7:0] m_p;
   logic [7:0] m_pl[$];
   logic [7:0] m_beats[$];
   logic [7:0] obs_q[$];
   logic [7:0] exp_q[$];

   logic [7:0] pl_mem [64];
   int         hold_plan [66];
   int         busy_mode = 0;
   int         wait_len = 2;
   int         got_status = 0;

   function automatic void chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void fail_wait(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: wait expired, required event not seen (t=%0t)", name, $time);
   endfunction

   // Compare process: check outputs, then predict what the coming edge does
   always @(negedge clk) begin
      if (rst) begin
         m_ph       = PIdle;
         m_done_exp = 0;
         m_pl.delete();
      end else begin
         chk("req_ready", int'(bus.req_ready), int'(m_ph == PIdle));
         chk("pl_ready", int'(bus.pl_ready), int'(m_ph == PCollect));
         chk("done", int'(bus.done), int'(m_done_exp));
         if (m_done_exp) chk("done_status", int'(bus.done_status), m_status);
         if (m_ph == PActive) begin
            chk($sformatf("data_out_beat%0d", m_idx), int'(bus.data_out), int'(m_beats[m_idx]));
            chk("pkt_valid", int'(bus.pkt_valid), int'(m_idx <= m_len));
         end else begin
            chk("data_out_quiet", int'(bus.data_out), 0);
            chk("pkt_valid_quiet", int'(bus.pkt_valid), 0);
         end

         m_nd = 0;
         case (m_ph)
            PIdle: begin
               if (bus.req_valid) begin
                  if (bus.req_len == 0 || bus.req_addr == 3) begin
                     m_nd     = 1;
                     m_status = 2;
                  end else begin
                     m_len  = int'(bus.req_len);
                     m_addr = int'(bus.req_addr);
                     m_cor  = bus.req_corrupt;
                     m_pl.delete();
                     m_ph   = PCollect;
                  end
               end
            end
            PCollect: begin
               if (bus.pl_valid) begin
                  m_pl.push_back(bus.pl_data);
                  if (m_pl.size() == m_len) begin
                     m_beats.delete();
                     m_p = 8'(m_len * 4 + m_addr);
                     m_beats.push_back(m_p);
                     foreach (m_pl[i]) begin
                        m_beats.push_back(m_pl[i]);
                        m_p = m_p ^ m_pl[i];
                     end
                     m_beats.push_back(m_cor ? ~m_p : m_p);
                     m_idx = 0;
                     m_ph  = PActive;
                  end
               end
            end
            PActive: begin
               if (!bus.busy) begin
                  obs_q.push_back(bus.data_out);
                  m_idx++;
                  if (m_idx == m_len + 2) begin
                     m_ph   = PWait;
                     m_seen = 0;
                  end
               end
            end
            PWait: begin
               if (bus.busy) begin
                  m_seen = 1;
               end else if (m_seen) begin
                  m_nd     = 1;
                  m_status = bus.err ? 1 : 0;
                  m_ph     = PIdle;
               end
            end
            default: m_ph = PIdle;
         endcase
         m_done_exp = m_nd;
      end
   end

   // Router busy model: per-beat holds, then a busy burst after the parity byte
   initial begin
      int bg_beat;
      int bg_hold;
      int bg_wait;
      bit bg_wstart;
      bg_beat   = -1;
      bg_hold   = 0;
      bg_wait   = 0;
      bg_wstart = 0;
      bus.busy  = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (m_ph == PActive) begin
            bg_wstart = 0;
            if (bg_beat != m_idx) begin
               bg_beat = m_idx;
               if (busy_mode != 0) bg_hold = ($urandom % 2 == 0) ? 0 : int'($urandom_range(1, 3));
               else bg_hold = hold_plan[m_idx];
            end
            if (bg_hold > 0) begin
               bus.busy = 1'b1;
               bg_hold--;
            end else begin
               bus.busy = 1'b0;
            end
         end else if (m_ph == PWait) begin
            bg_beat = -1;
            if (!bg_wstart) begin
               bg_wstart = 1;
               bg_wait   = wait_len;
            end
            if (bg_wait > 0) begin
               bus.busy = 1'b1;
               bg_wait--;
            end else begin
               bus.busy = 1'b0;
            end
         end else begin
            bg_beat   = -1;
            bg_wstart = 0;
            bus.busy  = (busy_mode != 0) ? 1'($urandom % 2) : 1'b0;
         end
      end
   end

   task automatic send_cmd(input int a, input int l, input bit c);
      int t = 0;
      bus.req_valid   = 1'b1;
      bus.req_addr    = 2'(a);
      bus.req_len     = 6'(l);
      bus.req_corrupt = c;
      @(negedge clk);
      while (!bus.req_ready && t < 200) begin
         t++;
         @(negedge clk);
      end
      if (!bus.req_ready) fail_wait("req_ready_wait");
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic send_payload(input int l, input bit gaps);
      for (int i = 0; i < l; i++) begin
         int t = 0;
         if (gaps && ($urandom % 3 == 0)) repeat ($urandom_range(1, 2)) @(posedge clk);
         #1;
         bus.pl_valid = 1'b1;
         bus.pl_data  = pl_mem[i];
         @(negedge clk);
         while (!bus.pl_ready && t < 200) begin
            t++;
            @(negedge clk);
         end
         if (!bus.pl_ready) fail_wait("pl_ready_wait");
         @(posedge clk);
         #1;
         bus.pl_valid = 1'b0;
      end
   endtask

   task automatic wait_done();
      int t = 0;
      @(negedge clk);
      while (!bus.done && t < 3000) begin
         t++;
         @(negedge clk);
      end
      if (bus.done) got_status = int'(bus.done_status);
      else begin
         fail_wait("done_wait");
         got_status = -1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_pkt(input int a, input int l, input bit c, input bit e, input bit gaps);
      obs_q.delete();
      bus.err = e;
      send_cmd(a, l, c);
      if (!(l == 0 || a == 3)) send_payload(l, gaps);
      wait_done();
   endtask

   task automatic chk_obs(input string tag);
      chk({tag, "_nbeats"}, obs_q.size(), exp_q.size());
      foreach (exp_q[i]) begin
         if (i < obs_q.size()) chk($sformatf("%s_b%0d", tag, i), int'(obs_q[i]), int'(exp_q[i]));
      end
   endtask

   task automatic clear_holds();
      foreach (hold_plan[i]) hold_plan[i] = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before the summary");
      $fatal(1, "watchdog");
   end

   initial begin
      int a;
      int l;
      bus.req_valid   = 1'b0;
      bus.req_addr    = '0;
      bus.req_len     = '0;
      bus.req_corrupt = 1'b0;
      bus.pl_valid    = 1'b0;
      bus.pl_data     = '0;
      bus.err         = 1'b0;
      clear_holds();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_req_ready", int'(bus.req_ready), 1);
      chk("reset_pkt_valid", int'(bus.pkt_valid), 0);
      chk("reset_data_out", int'(bus.data_out), 0);
      chk("reset_done", int'(bus.done), 0);
      @(posedge clk);
      #1;

      // Basic packet, addr 1 len 3
      pl_mem[0] = 8'h11; pl_mem[1] = 8'h22; pl_mem[2] = 8'h33;
      exp_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
      run_pkt(1, 3, 0, 0, 0);
      chk_obs("basic");
      chk("basic_status", got_status, 0);

      // Same packet with busy holds on header and on 0x22
      hold_plan[0] = 3;
      hold_plan[2] = 2;
      run_pkt(1, 3, 0, 0, 0);
      chk_obs("held");
      chk("held_status", got_status, 0);
      clear_holds();

      // Corrupted parity, router flags error
      exp_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'hF2};
      run_pkt(1, 3, 1, 1, 0);
      chk_obs("corrupt");
      chk("corrupt_status", got_status, 1);

      // Illegal commands
      run_pkt(0, 0, 0, 0, 0);
      chk("len0_status", got_status, 2);
      chk("len0_nbeats", obs_q.size(), 0);
      run_pkt(3, 5, 0, 0, 0);
      chk("addr3_status", got_status, 2);
      chk("addr3_nbeats", obs_q.size(), 0);

      // Max length, back to back so buffer pointers wrap
      for (int i = 0; i < 63; i++) pl_mem[i] = 8'(i);
      run_pkt(2, 63, 0, 0, 0);
      chk("max_a_nbeats", obs_q.size(), 65);
      if (obs_q.size() == 65) begin
         chk("max_a_header", int'(obs_q[0]), 8'hFE);
         chk("max_a_parity", int'(obs_q[64]), 8'hC1);
      end
      run_pkt(1, 63, 0, 0, 0);
      chk("max_b_nbeats", obs_q.size(), 65);
      if (obs_q.size() == 65) begin
         chk("max_b_header", int'(obs_q[0]), 8'hFD);
         chk("max_b_parity", int'(obs_q[64]), 8'hC2);
      end

      // Reset in the middle of the payload
      begin
         int t = 0;
         for (int i = 0; i < 10; i++) pl_mem[i] = 8'(i * 3 + 1);
         obs_q.delete();
         bus.err = 1'b0;
         send_cmd(1, 10, 0);
         send_payload(10, 0);
         while (obs_q.size() < 4 && t < 200) begin
            t++;
            @(posedge clk);
            #1;
         end
         if (obs_q.size() < 4) fail_wait("midpkt_wait");
         rst = 1'b1;
         @(posedge clk);
         #1;
         rst = 1'b0;
         @(negedge clk);
         chk("abort_pkt_valid", int'(bus.pkt_valid), 0);
         chk("abort_data_out", int'(bus.data_out), 0);
         chk("abort_req_ready", int'(bus.req_ready), 1);
         chk("abort_done", int'(bus.done), 0);
         repeat (4) @(posedge clk);
         #1;
      end
      pl_mem[0] = 8'h11; pl_mem[1] = 8'h22; pl_mem[2] = 8'h33;
      exp_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
      run_pkt(1, 3, 0, 0, 0);
      chk_obs("after_abort");
      chk("after_abort_status", got_status, 0);

      // Random traffic
      busy_mode = 1;
      for (int k = 0; k < 40; k++) begin
         a = ($urandom % 8 == 0) ? 3 : int'($urandom_range(0, 2));
         if ($urandom % 10 == 0) l = 0;
         else if ($urandom % 5 == 0) l = int'($urandom_range(40, 63));
         else l = int'($urandom_range(1, 12));
         for (int i = 0; i < 64; i++) pl_mem[i] = 8'($urandom);
         wait_len = int'($urandom_range(1, 3));
         run_pkt(a, l, 1'($urandom % 2), 1'($urandom % 2), 1);
      end

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
